// File: rtl/stamp_pkt_fifo_if.sv
// Bundle of the stamp_pkt_fifo write, read, budget and status signals.
// slave is the FIFO side; master is the producer/consumer side.
interface stamp_pkt_fifo_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEPTH_LOG2 = 12
);
  logic                  rxstrobe;
  logic [DATA_W-1:0]     data;
  logic                  init;
  logic [CNT_W-1:0]      num_data;
  logic                  clear_status;
  logic                  RD;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic [DEPTH_LOG2:0]   level;
  logic                  have_pkt_rdy;
  logic                  rx_overrun;
  logic                  fifo_hungry;

  modport master (
    output rxstrobe, data, init, num_data, clear_status, RD,
    input  rd_data, rd_valid, level, have_pkt_rdy, rx_overrun, fifo_hungry
  );

  modport slave (
    input  rxstrobe, data, init, num_data, clear_status, RD,
    output rd_data, rd_valid, level, have_pkt_rdy, rx_overrun, fifo_hungry
  );
endinterface

// File: rtl/stamp_pkt_fifo.sv
// Packet FIFO with per-packet serial stamping, burst-limited reads and a sample budget.
// Define MR_SERIAL_STAMP_EN to stamp serial nibbles into the first words of each packet.
module stamp_pkt_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STAMP_W    = 4,
  parameter int unsigned SERIAL_W   = 32,
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned CNT_W      = 16
) (
  input logic              rxclk,
  input logic              reset,
  stamp_pkt_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned SLOTS = SERIAL_W / STAMP_W;
  localparam int unsigned WC_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned BC_W  = $clog2(PKT_WORDS) + 1;

  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PKT_LVL   = (DEPTH_LOG2 + 1)'(PKT_WORDS);
  localparam logic [BC_W-1:0]     BURST_MAX = BC_W'(PKT_WORDS);
  localparam logic [CNT_W-1:0]    BUDGET_1  = CNT_W'(1);

  if ((SERIAL_W % STAMP_W) != 0 || SLOTS > PKT_WORDS || STAMP_W > DATA_W) begin : g_bad_cfg
    $error("stamp_pkt_fifo: inconsistent SERIAL_W/STAMP_W/PKT_WORDS/DATA_W");
  end

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [BC_W-1:0]       burst_q, burst_d;
  logic [CNT_W-1:0]      budget_q, budget_d;
  logic                  hungry_q, hungry_d;
  logic                  overrun_q, overrun_d;
  logic                  pkt_rdy_q;
  logic                  rd_valid_q;
  logic [DATA_W-1:0]     rd_data_q;

  logic                  full, empty, wr_en, rd_en;
  logic [DATA_W-1:0]     wr_word;

  // A pop in the same cycle never frees room for a write: full is the pre-edge level.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign wr_en = bus.rxstrobe & ~full;
  assign rd_en = bus.RD & ~empty & (burst_q < BURST_MAX);

`ifdef MR_SERIAL_STAMP_EN
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [SERIAL_W-1:0] serial_q, serial_d;
  logic [STAMP_W-1:0]  stamp;
  logic                stamp_hit;

  always_comb begin
    stamp     = '0;
    stamp_hit = 1'b0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (32'(wcnt_q) == s) begin
        stamp     = serial_q[s*STAMP_W +: STAMP_W];
        stamp_hit = 1'b1;
      end
    end
    wr_word = stamp_hit ? {stamp, bus.data[DATA_W-STAMP_W-1:0]} : bus.data;
  end

  always_comb begin
    wcnt_d   = wcnt_q;
    serial_d = serial_q;
    if (wr_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == WC_W'(PKT_WORDS - 1)) begin
        serial_d = serial_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      wcnt_q   <= '0;
      serial_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      serial_q <= serial_d;
    end
  end
`else
  assign wr_word = bus.data;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // burst_q counts RD-high cycles (not pops) and parks at PKT_WORDS until RD drops.
  always_comb begin
    burst_d = '0;
    if (bus.RD) begin
      burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
    end
  end

  always_comb begin
    budget_d = budget_q;
    hungry_d = hungry_q;
    if (bus.init) begin
      budget_d = bus.num_data;
      hungry_d = (bus.num_data != '0);
    end else if (wr_en && budget_q != '0) begin
      budget_d = budget_q - 1'b1;
      hungry_d = (budget_q != BUDGET_1);
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (bus.rxstrobe && full) begin
      overrun_d = 1'b1;
    end else if (bus.clear_status) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge rxclk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      burst_q    <= '0;
      budget_q   <= '0;
      hungry_q   <= 1'b0;
      overrun_q  <= 1'b0;
      pkt_rdy_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      burst_q    <= burst_d;
      budget_q   <= budget_d;
      hungry_q   <= hungry_d;
      overrun_q  <= overrun_d;
      pkt_rdy_q  <= (level_q >= PKT_LVL);
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.level        = level_q;
  assign bus.have_pkt_rdy = pkt_rdy_q;
  assign bus.rx_overrun   = overrun_q;
  assign bus.fifo_hungry  = hungry_q;

endmodule

// File: tb/tb_stamp_pkt_fifo.sv
// Directed bench for stamp_pkt_fifo with a read-data scoreboard.
// Honours MR_SERIAL_STAMP_EN when computing expected stamped words.
module tb_stamp_pkt_fifo;

  localparam int unsigned DEPTH = 4096;

`ifdef MR_SERIAL_STAMP_EN
  localparam logic [15:0] F123_FIRST = 16'h0123;
`else
  localparam logic [15:0] F123_FIRST = 16'hF123;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stamp_pkt_fifo_if #(.DATA_W(16), .CNT_W(16), .DEPTH_LOG2(12)) bus ();

  stamp_pkt_fifo #(
    .DATA_W(16), .STAMP_W(4), .SERIAL_W(32),
    .PKT_WORDS(256), .DEPTH_LOG2(12), .CNT_W(16)
  ) dut (
    .rxclk (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned pops        = 0;
  int unsigned m_level     = 0;
  int unsigned m_wcnt      = 0;
  logic [31:0] m_serial    = '0;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stored word for the next accepted write; advances the packet model.
  function automatic logic [15:0] stamp_word(input logic [15:0] d);
    logic [15:0] w;
    w = d;
`ifdef MR_SERIAL_STAMP_EN
    if (m_wcnt < 8) w = {m_serial[m_wcnt*4 +: 4], d[11:0]};
`endif
    if (m_wcnt == 255) m_serial = m_serial + 1;
    m_wcnt = (m_wcnt + 1) % 256;
    return w;
  endfunction

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      pops++;
      if (m_level > 0) m_level--;
      if (sb.size() == 0) chk("rd_unexpected", 32'(bus.rd_valid), 32'd0);
      else                chk("rd_data", 32'(bus.rd_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit wr_during);
    rst              = 1'b1;
    bus.rxstrobe     = wr_during;
    bus.data         = 16'hFFFF;
    bus.RD           = 1'b0;
    bus.init         = 1'b0;
    bus.clear_status = 1'b0;
    tick();
    rst          = 1'b0;
    bus.rxstrobe = 1'b0;
    sb.delete();
    m_level  = 0;
    m_wcnt   = 0;
    m_serial = '0;
  endtask

  task automatic write_n(input int n, input logic [15:0] val, input bit inc);
    bus.rxstrobe = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.data = inc ? 16'(i) : val;
      if (m_level < DEPTH) begin
        sb.push_back(stamp_word(bus.data));
        m_level++;
      end
      tick();
    end
    bus.rxstrobe = 1'b0;
  endtask

  task automatic read_cycles(input int n);
    bus.RD = 1'b1;
    repeat (n) tick();
    bus.RD = 1'b0;
    tick();
    tick();
  endtask

  int unsigned p0;
  int unsigned lvl;
  bit          hungry_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    bus.num_data = '0;
    do_reset(1'b1);
    do_reset(1'b0);
    chk("rst_level",    32'(bus.level), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data",  32'(bus.rd_data), 32'd0);
    chk("rst_pkt_rdy",  32'(bus.have_pkt_rdy), 32'd0);
    chk("rst_overrun",  32'(bus.rx_overrun), 32'd0);
    chk("rst_hungry",   32'(bus.fifo_hungry), 32'd0);

    read_cycles(5);
    chk("empty_rd_pops",  pops, 32'd0);
    chk("empty_rd_level", 32'(bus.level), 32'd0);

    bus.num_data = 16'd3;
    bus.init     = 1'b1;
    tick();
    bus.init = 1'b0;
    chk("init3_hungry", 32'(bus.fifo_hungry), 32'd1);
    for (int i = 0; i < 5; i++) begin
      write_n(1, 16'h0ABC, 1'b0);
      chk($sformatf("budget_w%0d_hungry", i), 32'(bus.fifo_hungry), 32'(hungry_exp[i]));
    end
    bus.num_data = 16'd2;
    bus.init     = 1'b1;
    write_n(1, 16'h0ABC, 1'b0);
    bus.init = 1'b0;
    chk("init_wins_hungry", 32'(bus.fifo_hungry), 32'd1);
    write_n(1, 16'h0ABC, 1'b0);
    chk("init2_w1_hungry", 32'(bus.fifo_hungry), 32'd1);
    write_n(1, 16'h0ABC, 1'b0);
    chk("init2_w2_hungry", 32'(bus.fifo_hungry), 32'd0);
    bus.num_data = 16'd0;
    bus.init     = 1'b1;
    tick();
    bus.init = 1'b0;
    chk("init0_hungry", 32'(bus.fifo_hungry), 32'd0);
    chk("budget_level", 32'(bus.level), 32'd8);
    p0 = pops;
    read_cycles(20);
    chk("budget_drain_pops", pops - p0, 32'd8);

    // Two packets of 0x0ABC: second packet carries serial 1 in its first word.
    do_reset(1'b0);
    write_n(255, 16'h0ABC, 1'b0);
    tick();
    chk("rdy_255", 32'(bus.have_pkt_rdy), 32'd0);
    write_n(1, 16'h0ABC, 1'b0);
    chk("rdy_latency", 32'(bus.have_pkt_rdy), 32'd0);
    tick();
    chk("rdy_256", 32'(bus.have_pkt_rdy), 32'd1);
    write_n(256, 16'h0ABC, 1'b0);
    tick();
    chk("pkt2_level", 32'(bus.level), 32'd512);
    p0 = pops;
    read_cycles(300);
    chk("pkt_burst1_pops", pops - p0, 32'd256);
    read_cycles(300);
    chk("pkt_burst2_pops", pops - p0, 32'd512);
    chk("pkt_empty_level", 32'(bus.level), 32'd0);
    chk("pkt_empty_rdy",   32'(bus.have_pkt_rdy), 32'd0);

    do_reset(1'b0);
    write_n(4096, 16'h0000, 1'b1);
    chk("full_level",   32'(bus.level), 32'd4096);
    chk("full_overrun", 32'(bus.rx_overrun), 32'd0);
    write_n(1, 16'hBEEF, 1'b0);
    chk("ovr_set",       32'(bus.rx_overrun), 32'd1);
    chk("ovr_set_level", 32'(bus.level), 32'd4096);
    bus.clear_status = 1'b1;
    write_n(1, 16'hBEEF, 1'b0);
    bus.clear_status = 1'b0;
    chk("ovr_set_wins", 32'(bus.rx_overrun), 32'd1);
    bus.clear_status = 1'b1;
    tick();
    bus.clear_status = 1'b0;
    chk("ovr_cleared", 32'(bus.rx_overrun), 32'd0);

    bus.RD = 1'b1;
    write_n(1, 16'hDEAD, 1'b0);
    bus.RD = 1'b0;
    tick();
    chk("no_rescue_level",   32'(bus.level), 32'd4095);
    chk("no_rescue_overrun", 32'(bus.rx_overrun), 32'd1);
    bus.clear_status = 1'b1;
    tick();
    bus.clear_status = 1'b0;
    write_n(1, 16'h0777, 1'b0);
    chk("refill_level", 32'(bus.level), 32'd4096);

    p0 = pops;
    read_cycles(300);
    chk("burst_cap_pops",  pops - p0, 32'd256);
    chk("burst_cap_level", 32'(bus.level), 32'd3840);
    p0 = pops;
    read_cycles(10);
    chk("burst_resume_pops", pops - p0, 32'd10);
    lvl = m_level;
    bus.RD = 1'b1;
    write_n(4, 16'h0055, 1'b0);
    bus.RD = 1'b0;
    tick();
    tick();
    chk("wr_rd_same_level", 32'(bus.level), lvl);

    // Reset in mid-packet with rxstrobe still asserted restarts serial numbering.
    do_reset(1'b0);
    write_n(100, 16'h0000, 1'b1);
    do_reset(1'b1);
    write_n(8, 16'hF123, 1'b0);
    chk("mid_rst_level", 32'(bus.level), 32'd8);
    tick();
    chk("mid_rst_rdy", 32'(bus.have_pkt_rdy), 32'd0);
    bus.RD = 1'b1;
    tick();
    bus.RD = 1'b0;
    chk("mid_rst_first_valid", 32'(bus.rd_valid), 32'd1);
    chk("mid_rst_first_data",  32'(bus.rd_data), 32'(F123_FIRST));
    tick();
    read_cycles(10);
    chk("mid_rst_drained", 32'(bus.level), 32'd0);

    do_reset(1'b0);
    write_n(16, 16'hF123, 1'b0);
    p0 = pops;
    read_cycles(20);
    chk("f123_pops",  pops - p0, 32'd16);
    chk("f123_level", 32'(bus.level), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
